uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised transmit FIFO between the memory-mapped CSR write path and the UART transmitter.
- Captures CSR writes to the TX data address in a single clock cycle.
- Presents data show-ahead to the transmitter over a valid/ready handshake.
- Reports occupancy, full, empty and a programmable almost-full level.
- Adds a synchronous flush, a sticky overflow flag and a drained pulse for interrupt logic.

Parameters:
- DATA_W, 8: width of each FIFO entry in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- ADDR_W, 32: CSR address bus width.
- TXDATA_ADDR, 2: CSR address that pushes into the FIFO.
- AW, $clog2(DEPTH): derived localparam. Not overridable.

Ports:
- clk  in  1  clock. All logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- csr_wr_en  in  1  CSR write strobe.
- csr_addr  in  ADDR_W  CSR address.
- csr_wdata  in  DATA_W  CSR write data.
- flush  in  1  synchronous clear of FIFO contents.
- clr_err  in  1  clears overflow.
- afull_thresh  in  AW+1  almost-full level. 0 disables almost_full.
- rd_ready  in  1  transmitter accepts the head entry.
- rd_valid  out  1  head entry is valid.
- rd_data  out  DATA_W  head entry (show-ahead).
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  afull_thresh != 0 and count >= afull_thresh.
- overflow  out  1  sticky: a push was attempted while full.
- drained  out  1  one-cycle pulse when the last entry is popped.

Behaviour:
- Reset (asynchronous):
  - Write and read pointers = 0, count = 0.
  - overflow = 0, drained = 0.
  - Resulting outputs: empty = 1, full = 0, rd_valid = 0, almost_full = 0.
  - Storage array is not reset. rd_data is don't-care while rd_valid = 0.
- Pointers: AW+1 bits, with the MSB used as the wrap bit.
  - empty when the pointers are fully equal.
  - full when the low AW bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH. Index into storage with the low AW bits.
- Push request: csr_wr_en && csr_addr == TXDATA_ADDR.
  - Accepted only if !full. The data is written to mem[wptr] at the same edge and wptr increments.
  - Zero-wait: no extra cycle between the strobe and the capture.
  - Back-to-back pushes on consecutive cycles are all accepted until full.
- Latency: an accepted push makes rd_valid = 1 at the next cycle when the FIFO was empty. Write-to-read latency is 1 cycle.
- Read side:
  - rd_valid = !empty. rd_data = mem[rptr[AW-1:0]], combinational from registered state.
  - Pop occurs when rd_valid && rd_ready: rptr increments. rd_ready while empty is ignored (no underflow is possible).
- Simultaneous push and pop:
  - Not full and not empty: both occur and count is unchanged.
  - Full: the pop occurs, the push is rejected and overflow is set. A full FIFO never accepts a write in the same cycle as a read.
  - Empty: only the push occurs.
- count is a registered up/down counter: +1 on push only, -1 on pop only. It must always equal wptr - rptr. The bench asserts this.
- flush: at the next edge, pointers and count are cleared.
  - Overrides any push or pop in the same cycle; that push is dropped and is not counted as overflow.
  - overflow is preserved. drained does not pulse on flush.
- overflow: set when a push request arrives while full. Cleared by clr_err. If set and clear coincide, set wins.
- drained: registered pulse, high for the one cycle after a pop that takes count from 1 to 0 with no push in that cycle.
- afull_thresh is sampled live. Values above DEPTH mean almost_full is never asserted.
- Reset asserted mid-burst: everything clears immediately. Operation resumes at the first edge after reset deasserts.

Decomposition:
- Package uart_fifo_pkg holds:
  - the CSR address constants (TXDATA_ADDR default, plus the future RX address);
  - a typedef for the fifo status struct (full, empty, almost_full, overflow, count) for CSR readback.
- Sub-module uart_fifo_mem: simple dual-port register array. One synchronous write port, one asynchronous read port, no reset. Parametrised by DATA_W and DEPTH, so it can be reused for the RX FIFO.
- The top holds the pointers, counter, flags and flag logic.

Test Plan:
- Reset, then 16 pushes of 0x10..0x1F on consecutive cycles with rd_ready = 0 -> count steps 1..16, full = 1 after the 16th, overflow = 0, rd_data = 0x10.
- 17th push of 0xAA while full -> rejected, overflow = 1, count = 16. clr_err -> overflow = 0. Then drain -> exact sequence 0x10..0x1F, no 0xAA.
- Push 0x55 into an empty FIFO with rd_ready = 1 held -> rd_valid high for exactly 1 cycle with 0x55, then drained pulses for 1 cycle, empty = 1.
- 40 cycles of concurrent push/pop at count = 5 (covers pointer wrap) -> count stays 5, data order preserved, count == wptr - rptr throughout.
- afull_thresh = 12: push 11 -> almost_full = 0; push 12th -> almost_full = 1. afull_thresh = 0 -> almost_full = 0.
- Flush with count = 9 plus a simultaneous push -> count = 0, empty = 1, no drained pulse, overflow unchanged. Assert reset mid-burst -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_fifo_pkg
// Shared definitions for the UART FIFO blocks.
//   CSR_TXDATA_ADDR / CSR_RXDATA_ADDR : CSR addresses of the TX and RX data
//                                       registers.
//   fifo_status_t                     : status word returned on CSR readback.
//   pack_status()                     : builds a status word from FIFO flags.
// -----------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int unsigned CSR_TXDATA_ADDR = 2;
    localparam int unsigned CSR_RXDATA_ADDR = 3;

    // Wide enough for any practical FIFO depth; narrower counts are zero-extended.
    localparam int unsigned FIFO_STATUS_CNT_W = 16;

    typedef struct packed {
        logic                         full;
        logic                         empty;
        logic                         almost_full;
        logic                         overflow;
        logic [FIFO_STATUS_CNT_W-1:0] count;
    } fifo_status_t;

    function automatic fifo_status_t pack_status(
        input logic                         full,
        input logic                         empty,
        input logic                         almost_full,
        input logic                         overflow,
        input logic [FIFO_STATUS_CNT_W-1:0] count
    );
        fifo_status_t s;
        s.full        = full;
        s.empty       = empty;
        s.almost_full = almost_full;
        s.overflow    = overflow;
        s.count       = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param_if
// CSR write path plus transmitter read handshake of the TX FIFO.
//   csr_wr_en, csr_addr, csr_wdata : CSR write strobe, address and data.
//   rd_valid, rd_ready, rd_data    : show-ahead valid/ready read handshake.
// Modports:
//   master : CSR write source and transmitter (drives writes and rd_ready).
//   slave  : the FIFO.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
);
    logic              csr_wr_en;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_wdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output csr_wr_en, csr_addr, csr_wdata, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  csr_wr_en, csr_addr, csr_wdata, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port, no reset. Shared by the TX and RX FIFOs.
//   clk     : write clock (rising edge)
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param
// Transmit FIFO between the CSR write path and the UART transmitter.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : CSR writes in, show-ahead valid/ready read out
//   flush        : synchronous clear of contents (overflow kept)
//   clr_err      : clears the sticky overflow flag
//   afull_thresh : almost-full level, 0 disables
//   count        : occupancy 0..DEPTH
//   full, empty, almost_full, overflow : status flags
//   drained      : one-cycle pulse after the last entry is popped
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module uart_tx_fifo_param
    import uart_fifo_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          DEPTH       = 16,
    parameter int          ADDR_W      = 32,
    parameter int unsigned TXDATA_ADDR = CSR_TXDATA_ADDR,
    localparam int         AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_fifo_param_if.slave   bus,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [AW:0]           afull_thresh,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  drained
);

    localparam logic [AW:0] ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              drained_q, drained_d;
    logic              push_req, push, pop;
    logic              full_w, empty_w;
    logic [DATA_W-1:0] rd_data_w;

    assign push_req = bus.csr_wr_en && (bus.csr_addr == ADDR_W'(TXDATA_ADDR));
    assign empty_w  = (wptr_q == rptr_q);
    assign full_w   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // A full FIFO rejects the write even when a pop frees a slot this cycle.
    // Flush overrides both sides of the handshake.
    assign push = push_req && !full_w && !flush;
    assign pop  = !empty_w && bus.rd_ready && !flush;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drained_d  = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + ONE;
            if (pop)  rptr_d = rptr_q + ONE;
            if (push && !pop)      count_d = count_q + ONE;
            else if (pop && !push) count_d = count_q - ONE;
            drained_d = pop && !push && (count_q == ONE);
        end
        // Set has priority over clear; a push dropped by flush is not an error.
        if (push_req && full_w && !flush) overflow_d = 1'b1;
        else if (clr_err)                 overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drained_q  <= drained_d;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (bus.csr_wdata),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (rd_data_w)
    );

    assign bus.rd_valid = !empty_w;
    assign bus.rd_data  = rd_data_w;

    assign count       = count_q;
    assign full        = full_w;
    assign empty       = empty_w;
    // Thresholds above DEPTH can never be reached, so almost_full stays low.
    assign almost_full = (afull_thresh != '0) && (count_q >= afull_thresh);
    assign overflow    = overflow_q;
    assign drained     = drained_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_param
// Self-checking bench for uart_tx_fifo_param. A queue-based reference model
// tracks contents, overflow and drained; each test task drives its scenario
// and compares DUT outputs against the model or fixed expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_param;
    import uart_fifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] TXA  = ADDR_W'(CSR_TXDATA_ADDR);
    localparam logic [ADDR_W-1:0] BADA = ADDR_W'(CSR_RXDATA_ADDR);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          clr_err;
    logic [AW:0]   afull_thresh;
    logic [AW:0]   count;
    logic          full, empty, almost_full, overflow, drained;

    uart_tx_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo_param #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TXDATA_ADDR (CSR_TXDATA_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush        (flush),
        .clr_err      (clr_err),
        .afull_thresh (afull_thresh),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .drained      (drained)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] mq [$];
    bit                m_ovf;
    bit                m_drn;

    int n_checks = 0;
    int n_pass   = 0;

    // Drive one cycle of stimulus, clock it, update the model, settle #1.
    task automatic cycle(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] d, input bit rdy,
                         input bit fl, input bit ce);
        bit preq, was_full, was_empty, do_push, do_pop;
        int sz;
        bus.csr_wr_en = wr;
        bus.csr_addr  = addr;
        bus.csr_wdata = d;
        bus.rd_ready  = rdy;
        flush         = fl;
        clr_err       = ce;
        sz        = mq.size();
        preq      = wr && (addr == TXA);
        was_full  = (sz == DEPTH);
        was_empty = (sz == 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_drn = 1'b0;
            if (ce) m_ovf = 1'b0;
            $display("flush");
        end else begin
            do_pop  = !was_empty && rdy;
            do_push = preq && !was_full;
            m_drn   = do_pop && !do_push && (sz == 1);
            if (preq && was_full) m_ovf = 1'b1;
            else if (ce)          m_ovf = 1'b0;
            if (do_pop) begin
                $display("pop  0x%02h", mq[0]);
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back(d);
                $display("push 0x%02h depth=%0d", d, mq.size());
            end
            if (preq && was_full) $display("push 0x%02h rejected (full)", d);
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.csr_wr_en = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.rd_ready = 1'b0;
        flush = 1'b0; clr_err = 1'b0; afull_thresh = 1;
        #1;
        n_checks++; if (count !== 0)        $display("FAIL rst_count got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1)     $display("FAIL rst_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0)      $display("FAIL rst_full got %b want 0", full); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", bus.rd_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0)  $display("FAIL rst_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (drained !== 1'b0)   $display("FAIL rst_drained got %b want 0", drained); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL rst_almost_full got %b want 0", almost_full); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_drn = 1'b0;
        @(posedge clk); #1;
        afull_thresh = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, TXA, DATA_W'(16 + i), 1'b0, 1'b0, 1'b0);
            n_checks++; if (count !== AW'(0) + (i + 1)) $display("FAIL fill_count got %0d want %0d", count, i + 1); else n_pass++;
            n_checks++; if (full !== (i == DEPTH - 1)) $display("FAIL fill_full got %b want %b", full, (i == DEPTH - 1)); else n_pass++;
        end
        n_checks++; if (overflow !== 1'b0)    $display("FAIL fill_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (bus.rd_data !== 8'h10) $display("FAIL fill_head got 0x%02h want 0x10", bus.rd_data); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL fill_rd_valid got %b want 1", bus.rd_valid); else n_pass++;
    endtask

    task automatic test_overflow_drain();
        cycle(1'b1, TXA, 8'hAA, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++; if (count !== 16)      $display("FAIL ovf_count got %0d want 16", count); else n_pass++;
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== DATA_W'(16 + i))
                $display("FAIL drain_data got v=%b 0x%02h want 0x%02h", bus.rd_valid, bus.rd_data, 16 + i);
            else n_pass++;
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_checks++; if (drained !== 1'b1)  $display("FAIL drain_pulse got %b want 1", drained); else n_pass++;
        n_checks++; if (empty !== 1'b1)    $display("FAIL drain_empty got %b want 1", empty); else n_pass++;
        idle();
        n_checks++; if (drained !== 1'b0)  $display("FAIL drain_pulse_end got %b want 0", drained); else n_pass++;
    endtask

    task automatic test_passthrough();
        cycle(1'b1, BADA, 8'h99, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 0) $display("FAIL wrong_addr_count got %0d want 0", count); else n_pass++;
        cycle(1'b1, TXA, 8'h55, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h55)
            $display("FAIL pass_head got v=%b 0x%02h want v=1 0x55", bus.rd_valid, bus.rd_data); else n_pass++;
        n_checks++; if (drained !== 1'b0) $display("FAIL pass_drained_early got %b want 0", drained); else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL pass_valid_1cyc got %b want 0", bus.rd_valid); else n_pass++;
        n_checks++; if (drained !== 1'b1) $display("FAIL pass_drained got %b want 1", drained); else n_pass++;
        n_checks++; if (empty !== 1'b1)   $display("FAIL pass_empty got %b want 1", empty); else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (drained !== 1'b0) $display("FAIL pass_drained_1cyc got %b want 0", drained); else n_pass++;
    endtask

    task automatic test_concurrent();
        logic [AW:0] diff;
        for (int i = 0; i < 5; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            n_checks++; if (bus.rd_data !== mq[0]) $display("FAIL conc_data got 0x%02h want 0x%02h", bus.rd_data, mq[0]); else n_pass++;
            cycle(1'b1, TXA, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
            n_checks++; if (count !== 5) $display("FAIL conc_count got %0d want 5", count); else n_pass++;
            diff = dut.wptr_q - dut.rptr_q;
            n_checks++; if (count !== diff) $display("FAIL conc_ptr_diff got count=%0d want %0d", count, diff); else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.rd_data !== mq[0]) $display("FAIL conc_tail got 0x%02h want 0x%02h", bus.rd_data, mq[0]); else n_pass++;
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL conc_empty got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_almost_full();
        afull_thresh = 12;
        for (int i = 0; i < 11; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (almost_full !== 1'b0) $display("FAIL af_11 got %b want 0", almost_full); else n_pass++;
        cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (almost_full !== 1'b1) $display("FAIL af_12 got %b want 1", almost_full); else n_pass++;
        afull_thresh = 0; #1;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL af_disabled got %b want 0", almost_full); else n_pass++;
        afull_thresh = 16; #1;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL af_16_at12 got %b want 0", almost_full); else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (almost_full !== 1'b1) $display("FAIL af_16_full got %b want 1", almost_full); else n_pass++;
        afull_thresh = 17; #1;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL af_above_depth got %b want 0", almost_full); else n_pass++;
        cycle(1'b1, TXA, 8'hAB, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL af_ovf got %b want 1", overflow); else n_pass++;
        afull_thresh = 0;
    endtask

    task automatic test_flush();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (count !== 0 || empty !== 1'b1) $display("FAIL flush_full got count=%0d empty=%b want 0/1", count, empty); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL flush_keep_ovf got %b want 1", overflow); else n_pass++;
        for (int i = 0; i < 9; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 9) $display("FAIL flush_pre9 got %0d want 9", count); else n_pass++;
        cycle(1'b1, TXA, 8'hEE, 1'b1, 1'b1, 1'b0);
        n_checks++; if (count !== 0)      $display("FAIL flush9_count got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1)   $display("FAIL flush9_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (drained !== 1'b0) $display("FAIL flush9_drained got %b want 0", drained); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL flush9_ovf got %b want 1", overflow); else n_pass++;
        idle();
        n_checks++; if (empty !== 1'b1 || drained !== 1'b0) $display("FAIL flush9_after got empty=%b drained=%b want 1/0", empty, drained); else n_pass++;
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) $display("FAIL flush_clr got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TXA, 8'h33, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL flush_full_push_ovf got %b want 0", overflow); else n_pass++;
        n_checks++; if (count !== 0)       $display("FAIL flush_full_push_count got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_random();
        logic [AW:0] diff;
        bit wr, rdy, fl, ce;
        logic [ADDR_W-1:0] a;
        int exp_af;
        afull_thresh = AW'(0) + $urandom_range(0, 20);
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom % 3) != 0;
            a   = (($urandom % 8) == 0) ? BADA : TXA;
            rdy = ($urandom % 2) != 0;
            fl  = ($urandom % 50) == 0;
            ce  = ($urandom % 20) == 0;
            cycle(wr, a, DATA_W'($urandom), rdy, fl, ce);
            exp_af = (afull_thresh != 0) && (mq.size() >= int'(afull_thresh));
            n_checks++; if (count !== mq.size()) $display("FAIL rnd_count got %0d want %0d", count, mq.size()); else n_pass++;
            n_checks++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty got %b want %b", empty, (mq.size() == 0)); else n_pass++;
            n_checks++; if (full !== (mq.size() == DEPTH)) $display("FAIL rnd_full got %b want %b", full, (mq.size() == DEPTH)); else n_pass++;
            n_checks++; if (bus.rd_valid !== (mq.size() != 0)) $display("FAIL rnd_rd_valid got %b want %b", bus.rd_valid, (mq.size() != 0)); else n_pass++;
            if (mq.size() != 0) begin
                n_checks++; if (bus.rd_data !== mq[0]) $display("FAIL rnd_rd_data got 0x%02h want 0x%02h", bus.rd_data, mq[0]); else n_pass++;
            end
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_overflow got %b want %b", overflow, m_ovf); else n_pass++;
            n_checks++; if (drained !== m_drn)  $display("FAIL rnd_drained got %b want %b", drained, m_drn); else n_pass++;
            n_checks++; if (almost_full !== exp_af[0]) $display("FAIL rnd_almost_full got %b want %b", almost_full, exp_af[0]); else n_pass++;
            diff = dut.wptr_q - dut.rptr_q;
            n_checks++; if (count !== diff) $display("FAIL rnd_ptr_diff got count=%0d want %0d", count, diff); else n_pass++;
        end
        afull_thresh = 0;
    endtask

    task automatic test_reset_midburst();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        afull_thresh = 4;
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, TXA, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1 || almost_full !== 1'b1)
            $display("FAIL mid_pre got ovf=%b af=%b want 1/1", overflow, almost_full); else n_pass++;
        bus.csr_wr_en = 1'b1; bus.rd_ready = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (count !== 0)          $display("FAIL mid_count got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL mid_flags got empty=%b full=%b want 1/0", empty, full); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL mid_rd_valid got %b want 0", bus.rd_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || almost_full !== 1'b0 || drained !== 1'b0)
            $display("FAIL mid_status got ovf=%b af=%b drn=%b want 0/0/0", overflow, almost_full, drained); else n_pass++;
        mq.delete(); m_ovf = 1'b0; m_drn = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        cycle(1'b1, TXA, 8'h77, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 1 || bus.rd_data !== 8'h77)
            $display("FAIL mid_resume got count=%0d data=0x%02h want 1/0x77", count, bus.rd_data); else n_pass++;
        afull_thresh = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout reached before test sequence completed");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_passthrough();
        test_concurrent();
        test_almost_full();
        test_flush();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
